usonic_frame_capture: RTL and testbench

- Parametrised successor to the single-channel ultrasonic sampler; runs on CLK_65 between the ultrasonic transducer, NUM_CH SPI ADC masters and the sample FIFO that feeds the MBED link.
- Organises acquisition into frames: emit a header word, fire a transmit burst, sample all channels synchronously for FRAME_TICKS periods, then idle GAP_TICKS periods.
- Writes channel-tagged words to the FIFO; halts cleanly on overflow.

---
 rtl/usonic_pkg.sv | 32 +++
 rtl/usonic_tx_gen.sv | 46 ++++
 rtl/usonic_frame_capture.sv | 168 ++++++++++++++++
 tb/tb_usonic_frame_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/usonic_pkg.sv
// Shared state encoding, word tags and default timing for the
// ultrasonic frame capture block (defaults assume a 65 MHz clock).
package usonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BURST,
        LISTEN,
        GAP,
        HALT
    } state_t;

    localparam logic HDR_TAG = 1'b1;
    localparam logic DAT_TAG = 1'b0;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_SAMPLE_DIV   = 1024;
    localparam int DEF_TX_HALF      = 819;
    localparam int DEF_BURST_PULSES = 32;
    localparam int DEF_FRAME_TICKS  = 1024;
    localparam int DEF_GAP_TICKS    = 64;

    function automatic int tag_bit(input int dw);
        return dw - 1;
    endfunction

    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usonic_tx_gen.sv
// Complementary transducer drive: a fixed count of full cycles,
// phase high first, restarted whenever enable is low.
module usonic_tx_gen
    import usonic_pkg::*;
#(
    parameter int TX_HALF      = DEF_TX_HALF,
    parameter int BURST_PULSES = DEF_BURST_PULSES
) (
    input  logic CLK_65,
    input  logic RST,
    input  logic en,
    output logic tx_p,
    output logic tx_n,
    output logic burst_done
);

    localparam int HW = $clog2(TX_HALF + 1);
    localparam int NW = $clog2(2 * BURST_PULSES + 1);
    localparam logic [HW-1:0] H_LAST = HW'(TX_HALF - 1);
    localparam logic [NW-1:0] N_LAST = NW'(2 * BURST_PULSES - 1);

    logic [HW-1:0] hcnt;
    logic [NW-1:0] half;
    logic          phase;
    logic          half_end;

    assign half_end   = (hcnt == H_LAST);
    assign burst_done = en && half_end && (half == N_LAST);
    assign tx_p       = en & phase;
    assign tx_n       = en & ~phase;

    always_ff @(posedge CLK_65) begin
        if (RST || !en) begin
            hcnt  <= '0;
            half  <= '0;
            phase <= 1'b1;
        end else if (half_end) begin
            hcnt  <= '0;
            half  <= half + 1'b1;
            phase <= ~phase;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/usonic_frame_capture.sv
// Frame sequencer: header word, transmit burst, synchronous multi-channel
// sampling and channel-tagged FIFO write-out; halts on FIFO overflow.
module usonic_frame_capture
    import usonic_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int TX_HALF      = DEF_TX_HALF,
    parameter int BURST_PULSES = DEF_BURST_PULSES,
    parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
    parameter int GAP_TICKS    = DEF_GAP_TICKS
) (
    input  logic                     CLK_65,
    input  logic                     RST,
    input  logic                     ON,
    input  logic [NUM_CH-1:0]        ADC_FIN,
    input  logic [NUM_CH*DATA_W-1:0] ADC_DATA,
    input  logic                     FIFO_FULL,
    output logic [NUM_CH-1:0]        ADC_EN,
    output logic                     TX_P,
    output logic                     TX_N,
    output logic                     FIFO_WR,
    output logic [DATA_W-1:0]        FIFO_DATA,
    output logic                     OVERFLOW,
    output logic                     MISSED,
    output logic                     FRAME_ACTIVE
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int SW    = DATA_W - CH_W - 1;
    localparam int TAG_B = tag_bit(DATA_W);
    localparam int TW    = $clog2(SAMPLE_DIV);
    localparam int IW    = $clog2(FRAME_TICKS + GAP_TICKS) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] T_MID  = TW'(SAMPLE_DIV / 2);
    localparam logic [TW-1:0] T_WEND = TW'(SAMPLE_DIV / 2 + NUM_CH);
    localparam logic [IW-1:0] F_LAST = IW'(FRAME_TICKS - 1);
    localparam logic [IW-1:0] G_LAST = IW'(GAP_TICKS - 1);

    state_t            state;
    logic [TW-1:0]     tick_cnt;
    logic [IW-1:0]     tick_idx;
    logic [DATA_W-2:0] frame_cnt;
    logic [NUM_CH-1:0] fin_q;
    logic [NUM_CH-1:0] got;
    logic [NUM_CH-1:0] rise;
    logic [SW-1:0]     smp [NUM_CH];
    logic              ovf_q;
    logic              miss_q;

    logic              sampling;
    logic              en_win;
    logic              hdr_due;
    logic              dat_due;
    logic              wr_due;
    logic              tick_wrap;
    logic              burst_done;
    logic [CH_W-1:0]   wr_ch;
    logic [DATA_W-1:0] wr_word;
    logic [NUM_CH*(CH_W+1)-1:0] unused_lsb;

    assign sampling  = (state == BURST) || (state == LISTEN);
    assign en_win    = sampling && (tick_cnt < T_MID);
    assign hdr_due   = (state == BURST) && (tick_idx == '0) && (tick_cnt == '0);
    assign dat_due   = sampling && (tick_cnt >= T_MID) && (tick_cnt < T_WEND);
    assign wr_due    = hdr_due | dat_due;
    assign wr_ch     = CH_W'(tick_cnt - T_MID);
    assign tick_wrap = (tick_cnt == T_LAST);
    assign rise      = ADC_FIN & ~fin_q;

    // Sample LSBs below the channel tag never reach the FIFO.
    always_comb begin
        unused_lsb = '0;
        for (int i = 0; i < NUM_CH; i++)
            unused_lsb[i*(CH_W+1) +: CH_W+1] = ADC_DATA[i*DATA_W +: CH_W+1];
    end

    always_comb begin
        wr_word = '0;
        wr_word[TAG_B] = hdr_due ? HDR_TAG : DAT_TAG;
        wr_word[TAG_B-1:0] = hdr_due ? frame_cnt : {wr_ch, smp[wr_ch]};
    end

    assign FIFO_WR      = wr_due & ~FIFO_FULL;
    assign FIFO_DATA    = FIFO_WR ? wr_word : '0;
    assign ADC_EN       = {NUM_CH{en_win}};
    assign FRAME_ACTIVE = sampling;
    assign OVERFLOW     = ovf_q;
    assign MISSED       = miss_q;

    usonic_tx_gen #(
        .TX_HALF      (TX_HALF),
        .BURST_PULSES (BURST_PULSES)
    ) u_tx (
        .CLK_65     (CLK_65),
        .RST        (RST),
        .en         (state == BURST),
        .tx_p       (TX_P),
        .tx_n       (TX_N),
        .burst_done (burst_done)
    );

    always_ff @(posedge CLK_65) begin
        if (RST || !ON) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            tick_idx  <= '0;
            frame_cnt <= '0;
            fin_q     <= '0;
            got       <= '0;
            ovf_q     <= 1'b0;
            miss_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                smp[i] <= '0;
        end else begin
            fin_q <= ADC_FIN;
            for (int i = 0; i < NUM_CH; i++) begin
                if (en_win && rise[i]) begin
                    smp[i] <= ADC_DATA[i*DATA_W+CH_W+1 +: SW];
                    got[i] <= 1'b1;
                end
            end
            if (dat_due) begin
                got[wr_ch] <= 1'b0;
                if (!got[wr_ch])
                    miss_q <= 1'b1;
            end
            if (state == BURST || state == LISTEN || state == GAP) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                if (tick_wrap)
                    tick_idx <= tick_idx + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    state    <= BURST;
                    tick_cnt <= '0;
                    tick_idx <= '0;
                end
                BURST: begin
                    if (burst_done)
                        state <= LISTEN;
                end
                LISTEN: begin
                    if (tick_wrap && tick_idx == F_LAST) begin
                        state     <= GAP;
                        tick_idx  <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (tick_wrap && tick_idx == G_LAST) begin
                        state    <= BURST;
                        tick_idx <= '0;
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
            // A refused word ends acquisition until a soft or hard reset.
            if (wr_due && FIFO_FULL) begin
                ovf_q <= 1'b1;
                state <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_usonic_frame_capture.sv
// Directed bench for usonic_frame_capture with a small ADC responder.
module tb_usonic_frame_capture;

    logic        CLK_65 = 1'b0;
    logic        RST;
    logic        ON;
    logic [1:0]  ADC_FIN;
    logic [31:0] ADC_DATA;
    logic        FIFO_FULL;
    logic [1:0]  ADC_EN;
    logic        TX_P;
    logic        TX_N;
    logic        FIFO_WR;
    logic [15:0] FIFO_DATA;
    logic        OVERFLOW;
    logic        MISSED;
    logic        FRAME_ACTIVE;

    int checks = 0;
    int failures = 0;
    logic [1:0] blk = 2'b00;
    int en_age [2];

    int wr_off [$];
    logic [15:0] wr_dat [$];
    int exp_off [10] = '{0, 8, 9, 24, 25, 40, 41, 56, 57, 96};
    logic [15:0] exp_dat [10] = '{16'h8000, 16'h2AF3, 16'h448D,
                                  16'h2AF3, 16'h448D, 16'h2AF3,
                                  16'h448D, 16'h2AF3, 16'h448D,
                                  16'h8001};
    logic [15:0] txp_v;
    logic [15:0] txn_v;
    int fa_cnt;
    int tx_late;
    int gap_act;
    int halt_act;
    int idle_wr;

    usonic_frame_capture #(
        .NUM_CH       (2),
        .DATA_W       (16),
        .SAMPLE_DIV   (16),
        .TX_HALF      (4),
        .BURST_PULSES (2),
        .FRAME_TICKS  (4),
        .GAP_TICKS    (2)
    ) dut (
        .CLK_65       (CLK_65),
        .RST          (RST),
        .ON           (ON),
        .ADC_FIN      (ADC_FIN),
        .ADC_DATA     (ADC_DATA),
        .FIFO_FULL    (FIFO_FULL),
        .ADC_EN       (ADC_EN),
        .TX_P         (TX_P),
        .TX_N         (TX_N),
        .FIFO_WR      (FIFO_WR),
        .FIFO_DATA    (FIFO_DATA),
        .OVERFLOW     (OVERFLOW),
        .MISSED       (MISSED),
        .FRAME_ACTIVE (FRAME_ACTIVE)
    );

    always #5 CLK_65 = ~CLK_65;

    task automatic step();
        @(posedge CLK_65);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC responder: FIN rises on the third enabled cycle, drops with EN.
    initial begin
        ADC_FIN = 2'b00;
        en_age[0] = 0;
        en_age[1] = 0;
        forever begin
            @(posedge CLK_65);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (ADC_EN[i]) begin
                    en_age[i] = en_age[i] + 1;
                    if (en_age[i] == 3 && !blk[i])
                        ADC_FIN[i] = 1'b1;
                end else begin
                    en_age[i] = 0;
                    ADC_FIN[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        ON = 1'b0;
        FIFO_FULL = 1'b0;
        ADC_DATA = {16'h1234, 16'hABCD};
        fa_cnt = 0;
        tx_late = 0;
        gap_act = 0;
        halt_act = 0;
        idle_wr = 0;
        txp_v = '0;
        txn_v = '0;
        repeat (3) step();
        RST = 1'b0;
        step();

        check("rst_active", FRAME_ACTIVE, 0);
        check("rst_wr", FIFO_WR, 0);
        check("rst_tx", {TX_P, TX_N}, 0);
        check("rst_en", ADC_EN, 0);
        check("rst_flags", {OVERFLOW, MISSED}, 0);

        ON = 1'b1;
        for (int off = 0; off <= 96; off++) begin
            step();
            if (FIFO_WR) begin
                wr_off.push_back(off);
                wr_dat.push_back(FIFO_DATA);
            end
            if (off < 16) begin
                txp_v = {txp_v[14:0], TX_P};
                txn_v = {txn_v[14:0], TX_N};
            end else if (off < 96 && (TX_P || TX_N)) begin
                tx_late++;
            end
            if (off < 96 && FRAME_ACTIVE)
                fa_cnt++;
            if (off >= 64 && off < 96 && (ADC_EN != 0 || FIFO_WR))
                gap_act++;
            if (off == 0)
                check("burst_en", ADC_EN, 2'b11);
            if (off == 40)
                check("missed_pre", MISSED, 0);
            if (off == 42)
                check("missed_post", MISSED, 1);
            if (off == 31)
                blk[1] = 1'b1;
            if (off == 47)
                blk[1] = 1'b0;
        end

        check("tx_p_pat", txp_v, 16'hF0F0);
        check("tx_n_pat", txn_v, 16'h0F0F);
        check("tx_after", tx_late, 0);
        check("active_len", fa_cnt, 64);
        check("gap_quiet", gap_act, 0);
        check("wr_count", wr_off.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < wr_off.size()) begin
                check($sformatf("wr%0d_off", i), wr_off[i], exp_off[i]);
                check($sformatf("wr%0d_dat", i), wr_dat[i], exp_dat[i]);
            end
        end

        repeat (8) step();
        check("f1_ch0_wr", FIFO_WR, 1);
        check("f1_ch0_dat", FIFO_DATA, 16'h2AF3);
        step();
        FIFO_FULL = 1'b1;
        #1;
        check("full_wr", FIFO_WR, 0);
        check("full_ovf_pre", OVERFLOW, 0);
        step();
        check("halt_ovf", OVERFLOW, 1);
        check("halt_missed", MISSED, 1);
        check("halt_active", FRAME_ACTIVE, 0);
        check("halt_en", ADC_EN, 0);
        check("halt_tx", {TX_P, TX_N}, 0);
        FIFO_FULL = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (FIFO_WR || FRAME_ACTIVE || ADC_EN != 0 || TX_P || TX_N)
                halt_act++;
        end
        check("halt_quiet", halt_act, 0);
        check("halt_sticky", OVERFLOW, 1);

        ON = 1'b0;
        step();
        check("soft_rst_flags", {OVERFLOW, MISSED}, 0);
        ON = 1'b1;
        step();
        check("rehdr_wr", FIFO_WR, 1);
        check("rehdr_dat", FIFO_DATA, 16'h8000);

        repeat (5) step();
        check("mid_tx", {TX_P, TX_N}, 2'b01);
        ON = 1'b0;
        step();
        check("drop_tx", {TX_P, TX_N}, 0);
        check("drop_active", FRAME_ACTIVE, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (FIFO_WR)
                idle_wr++;
        end
        check("drop_no_wr", idle_wr, 0);
        ON = 1'b1;
        step();
        check("reon_wr", FIFO_WR, 1);
        check("reon_dat", FIFO_DATA, 16'h8000);
        check("reon_tx", {TX_P, TX_N}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
